ov7670_config_seq: RTL and testbench

Configuration sequencer that walks the OV7670 configuration ROM from address 0 and turns each 16-bit entry into an SCCB bus transaction or a timed pause.
- It drives the ROM's address and clock-enable and decodes the registered ROM output.
- It issues write and read commands to the SCCB master over a valid/ready handshake with a separate response strobe.
- It reports completion, read-back data and a sticky NACK flag to the top-level camera init logic.

---
 rtl/ov7670_config_seq.sv | 136 +++++++++++++
 tb/tb_ov7670_config_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_seq.sv
// OV7670 configuration sequencer: walks the config ROM from address 0 and turns
// each entry into an SCCB write, an SCCB read-back, a timed pause or the end marker.
module ov7670_config_seq #(
    parameter int DELAY_CYCLES = 250000,
    parameter int CNT_W        = $clog2(DELAY_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    output logic        rom_clk_en,
    input  logic [15:0] rom_dout,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_rw,
    output logic [7:0]  cmd_reg,
    output logic [7:0]  cmd_wdata,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    input  logic [7:0]  rsp_rdata,
    output logic        rd_valid,
    output logic [7:0]  rd_reg,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic        nack_err
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, DELAY, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY_CYCLES - 1);

    state_t           state;
    logic [7:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic             advance;

    // An entry is finished either by its SCCB response or by the pause running out.
    assign advance = (state == WAIT_RSP && rsp_valid) || (state == DELAY && cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 8'd0;
            cnt        <= '0;
            rom_addr   <= 8'd0;
            rom_clk_en <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_rw     <= 1'b0;
            cmd_reg    <= 8'd0;
            cmd_wdata  <= 8'd0;
            rd_valid   <= 1'b0;
            rd_reg     <= 8'd0;
            rd_data    <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            nack_err   <= 1'b0;
        end else begin
            rd_valid   <= 1'b0;
            rom_clk_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx        <= 8'd0;
                        nack_err   <= 1'b0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        rom_addr   <= 8'd0;
                        rom_clk_en <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    if (rom_dout == 16'hFFFF) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (rom_dout == 16'hFFF0) begin
                        cnt   <= CNT_LOAD;
                        state <= DELAY;
                    end else begin
                        cmd_valid <= 1'b1;
                        state     <= ISSUE;
                        // Register 0xFE is a pseudo-address marking a read-back of val.
                        if (rom_dout[15:8] == 8'hFE) begin
                            cmd_rw    <= 1'b1;
                            cmd_reg   <= rom_dout[7:0];
                            cmd_wdata <= 8'd0;
                        end else begin
                            cmd_rw    <= 1'b0;
                            cmd_reg   <= rom_dout[15:8];
                            cmd_wdata <= rom_dout[7:0];
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_valid) begin
                        if (rsp_nack) begin
                            nack_err <= 1'b1;
                        end else if (cmd_rw) begin
                            rd_valid <= 1'b1;
                            rd_reg   <= cmd_reg;
                            rd_data  <= rsp_rdata;
                        end
                    end
                end
                DELAY: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                default: state <= IDLE;
            endcase

            // The index never wraps: finishing entry 255 ends the sequence.
            if (advance) begin
                if (idx == 8'hFF) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    idx        <= idx + 8'd1;
                    rom_addr   <= idx + 8'd1;
                    rom_clk_en <= 1'b1;
                    state      <= FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Bench for ov7670_config_seq: ROM and SCCB master models plus a queue-based
// reference of the command/fetch stream derived from the ROM contents.
module tb_ov7670_config_seq;

    localparam int DLY = 8;

    typedef struct packed {
        logic       rw;
        logic [7:0] r;
        logic [7:0] d;
    } cmd_t;

    logic        clk, rst_n, start;
    logic [7:0]  rom_addr;
    logic        rom_clk_en;
    logic [15:0] rom_dout;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [7:0]  cmd_reg, cmd_wdata;
    logic        rsp_valid, rsp_nack;
    logic [7:0]  rsp_rdata;
    logic        rd_valid;
    logic [7:0]  rd_reg, rd_data;
    logic        busy, done, nack_err;

    ov7670_config_seq #(.DELAY_CYCLES(DLY)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_clk_en(rom_clk_en), .rom_dout(rom_dout),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
        .rd_valid(rd_valid), .rd_reg(rd_reg), .rd_data(rd_data),
        .busy(busy), .done(done), .nack_err(nack_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] rom [256];
    logic [7:0]  exp_addr [$];
    cmd_t        exp_cmd [$];
    cmd_t        acc_log [$];
    logic [15:0] rd_log [$];
    int          fetch_cyc [256];

    int   ready_mode, hold_n, hold_ctr, lat_min, lat_max, nack_mode, nack_nth, rsp_count;
    bit   rdata_fix_en, spurious_en;
    logic [7:0] rdata_fix;

    bit   pend, real_rsp, exp_nack, exp_rd, prev_stall;
    int   lat_ctr, stall_run, last_stall, cyc;
    cmd_t cur, prev_cmd;
    logic [7:0] exp_rd_reg, exp_rd_data;

    always @(posedge clk) if (rom_clk_en) rom_dout <= rom[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected fetch addresses and SCCB commands, straight from the entry rules.
    task automatic build_expect();
        exp_addr.delete();
        exp_cmd.delete();
        for (int i = 0; i < 256; i++) begin
            exp_addr.push_back(8'(i));
            if (rom[i] == 16'hFFFF) break;
            if (rom[i] != 16'hFFF0) begin
                if (rom[i][15:8] == 8'hFE) exp_cmd.push_back({1'b1, rom[i][7:0], 8'h00});
                else                       exp_cmd.push_back({1'b0, rom[i][15:8], rom[i][7:0]});
            end
        end
    endtask

    // Per-cycle SCCB master model and comparator, evaluated on the falling edge.
    initial begin
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend = 0; exp_rd = 0; exp_nack = 0; prev_stall = 0; stall_run = 0;
                cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = 8'h00;
            end else begin
                check("nack_err", nack_err, exp_nack);
                check("rd_valid", rd_valid, exp_rd);
                if (exp_rd) begin
                    check("rd_reg", rd_reg, exp_rd_reg);
                    check("rd_data", rd_data, exp_rd_data);
                end
                if (rd_valid) rd_log.push_back({rd_reg, rd_data});
                check("busy_and_done", busy & done, 0);
                if (prev_stall) begin
                    check("stall_cmd", {cmd_valid, cmd_rw, cmd_reg, cmd_wdata}, {1'b1, prev_cmd});
                    check("stall_no_fetch", rom_clk_en, 0);
                end
                if (rom_clk_en) begin
                    checks++;
                    if (exp_addr.size() == 0) begin
                        errors++;
                        $display("FAIL fetch_addr: got fetch of %0h expected no fetch", rom_addr);
                    end else begin
                        logic [7:0] a;
                        a = exp_addr.pop_front();
                        if (rom_addr !== a) begin
                            errors++;
                            $display("FAIL fetch_addr: got %0h expected %0h", rom_addr, a);
                        end
                        fetch_cyc[a] = cyc;
                    end
                end

                rsp_valid = 1'b0; rsp_nack = 1'b0; real_rsp = 0;
                if (pend) begin
                    if (lat_ctr == 0) begin
                        rsp_valid = 1'b1; real_rsp = 1; pend = 0; rsp_count++;
                        rsp_nack  = (nack_mode == 1) ? ($urandom_range(3, 0) == 0)
                                                     : (nack_mode == 2 && rsp_count == nack_nth);
                        rsp_rdata = rdata_fix_en ? rdata_fix : 8'($urandom);
                    end else begin
                        lat_ctr--;
                    end
                end else if (spurious_en && !cmd_valid && $urandom_range(7, 0) == 0) begin
                    rsp_valid = 1'b1; rsp_nack = 1'b1; rsp_rdata = 8'($urandom);
                end
                case (ready_mode)
                    0: cmd_ready = 1'b1;
                    1: cmd_ready = 1'($urandom_range(1, 0));
                    default: begin
                        if (cmd_valid && hold_ctr < hold_n) begin
                            cmd_ready = 1'b0;
                            hold_ctr++;
                        end else begin
                            cmd_ready = 1'b1;
                        end
                    end
                endcase

                exp_rd = 0;
                if (start && !busy) exp_nack = 0;
                if (cmd_valid && cmd_ready) begin
                    cmd_t got;
                    got = {cmd_rw, cmd_reg, cmd_wdata};
                    acc_log.push_back(got);
                    checks++;
                    if (exp_cmd.size() == 0) begin
                        errors++;
                        $display("FAIL cmd: got %0h expected no command", got);
                        cur = got;
                    end else begin
                        cur = exp_cmd.pop_front();
                        if (got !== cur) begin
                            errors++;
                            $display("FAIL cmd: got %0h expected %0h", got, cur);
                        end
                    end
                    pend = 1;
                    lat_ctr = $urandom_range(lat_max, lat_min);
                    last_stall = stall_run;
                    stall_run = 0;
                end else if (cmd_valid) begin
                    stall_run++;
                end
                if (real_rsp) begin
                    if (rsp_nack) exp_nack = 1;
                    else if (cur.rw) begin
                        exp_rd = 1; exp_rd_reg = cur.r; exp_rd_data = rsp_rdata;
                    end
                end
                prev_stall = cmd_valid && !cmd_ready;
                prev_cmd   = {cmd_rw, cmd_reg, cmd_wdata};
            end
        end
    end

    task automatic cfg(input int rm, input int lmin, input int lmax, input int nm, input bit sp);
        ready_mode = rm; lat_min = lmin; lat_max = lmax; nack_mode = nm; spurious_en = sp;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_side"}, {rom_addr, rom_clk_en, cmd_valid, cmd_rw, cmd_reg, cmd_wdata}, 0);
        check({tag, "_status"}, {rd_valid, rd_reg, rd_data, busy, done, nack_err}, 0);
    endtask

    task automatic pulse_start();
        build_expect();
        acc_log.delete(); rd_log.delete();
        rsp_count = 0; hold_ctr = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_seq(input int budget, input bit extra);
        int n;
        pulse_start();
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (!done && extra && $urandom_range(7, 0) == 0) start = 1'b1;
            n++;
        end
        start = 1'b0;
        check("done_reached", done, 1);
        check("busy_at_end", busy, 0);
        check("cmds_left", exp_cmd.size(), 0);
        check("fetches_left", exp_addr.size(), 0);
    endtask

    task automatic rom_fill(input logic [15:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    initial begin
        int n;
        start = 1'b0; rst_n = 1'b1;
        rdata_fix_en = 0; rdata_fix = 8'h00; hold_n = 0; nack_nth = 0;
        cfg(0, 0, 0, 0, 0);
        rom_fill(16'hFFFF);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        rst_n = 1'b1;

        // Four-entry table with a read-back at the end.
        rom[0] = 16'h1280; rom[1] = 16'h1205; rom[2] = 16'h3A06; rom[3] = 16'hFE1A;
        rdata_fix_en = 1; rdata_fix = 8'h76;
        run_seq(200, 0);
        check("t1_ncmd", acc_log.size(), 4);
        check("t1_cmd0", acc_log[0], {1'b0, 8'h12, 8'h80});
        check("t1_cmd1", acc_log[1], {1'b0, 8'h12, 8'h05});
        check("t1_cmd2", acc_log[2], {1'b0, 8'h3A, 8'h06});
        check("t1_cmd3", acc_log[3], {1'b1, 8'h1A, 8'h00});
        check("t1_rd", rd_log[0], 16'h1A76);
        check("t1_end_addr", rom_addr, 8'h04);
        rdata_fix_en = 0;

        // Pause entry: FETCH and DECODE of address 1, then DLY cycles of DELAY.
        rom_fill(16'hFFFF);
        rom[0] = 16'h1301; rom[1] = 16'hFFF0; rom[2] = 16'h1402;
        run_seq(200, 0);
        check("delay_gap", fetch_cyc[2] - fetch_cyc[1], DLY + 2);

        // Back-pressure: ready held low for 20 cycles of cmd_valid.
        rom_fill(16'hFFFF);
        rom[0] = 16'h1522;
        cfg(2, 0, 0, 0, 0); hold_n = 20;
        run_seq(200, 0);
        check("stall_len", last_stall, 20);
        check("stall_cmd0", acc_log[0], {1'b0, 8'h15, 8'h22});

        // NACK on the second response is sticky but not fatal.
        rom_fill(16'hFFFF);
        rom[0] = 16'h1601; rom[1] = 16'h1702; rom[2] = 16'h1803; rom[3] = 16'hFE04;
        cfg(0, 0, 1, 2, 0); nack_nth = 2;
        run_seq(300, 0);
        check("nack_sticky", nack_err, 1);
        check("nack_ncmd", acc_log.size(), 4);
        cfg(0, 0, 1, 0, 0);
        run_seq(300, 0);
        check("nack_cleared", nack_err, 0);

        // Asynchronous reset while waiting for a response.
        cfg(0, 10, 10, 0, 0);
        pulse_start();
        n = 0;
        while (!pend && n < 50) begin @(posedge clk); #1; n++; end
        check("rst_wait_reached", pend, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        repeat (2) @(posedge clk);
        exp_addr.delete(); exp_cmd.delete();
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("idle_after_reset", {busy, done, rom_clk_en, cmd_valid}, 0);
        cfg(0, 0, 0, 0, 0);
        run_seq(300, 0);
        check("restart_ncmd", acc_log.size(), 4);

        // No end marker anywhere: 256 writes, then DONE without wrapping.
        for (int i = 0; i < 256; i++) rom[i] = {8'($urandom_range(253, 0)), 8'($urandom)};
        run_seq(3000, 0);
        check("full_ncmd", acc_log.size(), 256);
        check("full_end_addr", rom_addr, 8'hFF);
        repeat (6) @(posedge clk);
        #1 check("full_done_held", done, 1);

        // Randomised tables with back-pressure, latency, NACKs, stray responses and extra starts.
        cfg(1, 0, 3, 1, 1);
        for (int t = 0; t < 4; t++) begin
            int len;
            len = $urandom_range(40, 10);
            for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
            for (int i = 0; i < len; i++) begin
                int k;
                k = $urandom_range(9, 0);
                if (k == 0)      rom[i] = 16'hFFF0;
                else if (k < 3)  rom[i] = {8'hFE, 8'($urandom)};
                else             rom[i] = {8'($urandom_range(253, 0)), 8'($urandom)};
            end
            rom[len] = 16'hFFFF;
            run_seq(4000, 1);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
